// File: rtl/cmd_pkg.sv
// Shared types and constants for the command-path status responder.
package cmd_pkg;

  localparam int MAX_CH = 8;
  localparam int CH_W   = $clog2(MAX_CH);
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_MASK,
    ST_DATA,
    ST_CSUM
  } state_t;

endpackage

// File: rtl/cmd_req_edge.sv
// Registered rising-edge detector: evt is high for the one cycle where req
// is high now but was low at the previous edge.
module cmd_req_edge (
  input  logic CLK,
  input  logic rst_n,
  input  logic req,
  output logic evt
);

  logic prev;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= req;
  end

  assign evt = req & ~prev;

endmodule

// File: rtl/cmd_status_frame.sv
// Snapshots status channels on a request and streams them as a framed byte
// sequence: header, mask, selected channel bytes, optional XOR checksum.
module cmd_status_frame
  import cmd_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter int         CH_BYTES = 1,
  parameter logic [7:0] HEADER   = DEFAULT_HEADER,
  parameter bit         CSUM_EN  = 1'b1
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         status_req,
  input  logic [NUM_CH-1:0]            status_mask,
  input  logic [NUM_CH*CH_BYTES*8-1:0] status_in,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         BUSY,
  output logic                         req_dropped
);

  localparam int SNAP_W = NUM_CH*CH_BYTES*8;
  localparam int BIDX_W = (CH_BYTES > 1) ? $clog2(CH_BYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_B = BIDX_W'(CH_BYTES-1);

  state_t              state;
  logic                evt;
  logic [NUM_CH-1:0]   mask_q, pend_mask, start_mask;
  logic [SNAP_W-1:0]   snap;
  logic [CH_W-1:0]     ch_q, first_ch, nxt_ch;
  logic                has_nxt;
  logic [BIDX_W-1:0]   bidx;
  logic [7:0]          csum, csum_n, mask8;
  logic                pend_vld, xfer, start, take, store;

  cmd_req_edge u_edge (
    .CLK   (CLK),
    .rst_n (rst_n),
    .req   (status_req),
    .evt   (evt)
  );

  function automatic logic [7:0] pick(input logic [SNAP_W-1:0] s, input int c, input int b);
    int idx;
    idx = c*CH_BYTES + b;
    if (idx < NUM_CH*CH_BYTES) pick = s[idx*8 +: 8];
    else                       pick = 8'h00;
  endfunction

  assign xfer       = tx_valid && tx_ready;
  assign csum_n     = csum ^ tx_data;
  assign start      = (state == ST_IDLE) && (pend_vld || evt);
  assign start_mask = pend_vld ? pend_mask : status_mask;
  assign take       = (state == ST_IDLE) && pend_vld;
  assign store      = evt && ((state != ST_IDLE) || pend_vld);

  always_comb begin
    mask8 = '0;
    mask8[NUM_CH-1:0] = mask_q;
  end

  // Priority scan: lowest selected channel, and lowest selected above ch_q.
  always_comb begin
    first_ch = '0;
    nxt_ch   = '0;
    has_nxt  = 1'b0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (mask_q[i]) first_ch = CH_W'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_ch  = CH_W'(i);
        has_nxt = 1'b1;
      end
    end
  end

  // Single pending slot holds only the mask; data is snapshotted at frame start.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld    <= 1'b0;
      pend_mask   <= '0;
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= 1'b0;
      if (take) pend_vld <= 1'b0;
      if (store) begin
        if (pend_vld && !take) begin
          req_dropped <= 1'b1;
        end else begin
          pend_vld  <= 1'b1;
          pend_mask <= status_mask;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      snap     <= '0;
      ch_q     <= '0;
      bidx     <= '0;
      csum     <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask_q   <= start_mask;
            snap     <= status_in;
            csum     <= '0;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            BUSY     <= 1'b1;
            state    <= ST_HDR;
          end else begin
            BUSY <= 1'b0;
          end
        end
        ST_HDR: if (xfer) begin
          csum    <= csum_n;
          tx_data <= mask8;
          state   <= ST_MASK;
        end
        ST_MASK: if (xfer) begin
          csum <= csum_n;
          if (|mask_q) begin
            ch_q    <= first_ch;
            bidx    <= '0;
            tx_data <= pick(snap, int'(first_ch), 0);
            state   <= ST_DATA;
          end else if (CSUM_EN) begin
            tx_data <= csum_n;
            state   <= ST_CSUM;
          end else begin
            tx_valid <= 1'b0;
            BUSY     <= pend_vld || evt;
            state    <= ST_IDLE;
          end
        end
        ST_DATA: if (xfer) begin
          csum <= csum_n;
          if (bidx != LAST_B) begin
            bidx    <= bidx + 1'b1;
            tx_data <= pick(snap, int'(ch_q), int'(bidx) + 1);
          end else if (has_nxt) begin
            ch_q    <= nxt_ch;
            bidx    <= '0;
            tx_data <= pick(snap, int'(nxt_ch), 0);
          end else if (CSUM_EN) begin
            tx_data <= csum_n;
            state   <= ST_CSUM;
          end else begin
            tx_valid <= 1'b0;
            BUSY     <= pend_vld || evt;
            state    <= ST_IDLE;
          end
        end
        ST_CSUM: if (xfer) begin
          tx_valid <= 1'b0;
          BUSY     <= pend_vld || evt;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_status_frame.sv
// Directed bench for cmd_status_frame (NUM_CH=4, CH_BYTES=2), with a second
// instance built without the checksum byte.
module tb_cmd_status_frame;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        status_req;
  logic [3:0]  status_mask;
  logic [63:0] status_in;
  logic        tx_ready;
  logic [7:0]  tx_data, tx_data0;
  logic        tx_valid, tx_valid0;
  logic        BUSY, BUSY0;
  logic        req_dropped, req_dropped0;

  int checks = 0;
  int errors = 0;
  logic [7:0] fr [0:7];

  always #5 CLK = ~CLK;

  cmd_status_frame #(.NUM_CH(4), .CH_BYTES(2), .HEADER(8'hA5), .CSUM_EN(1'b1)) dut (
    .CLK(CLK), .rst_n(rst_n), .status_req(status_req), .status_mask(status_mask),
    .status_in(status_in), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .BUSY(BUSY), .req_dropped(req_dropped)
  );

  cmd_status_frame #(.NUM_CH(4), .CH_BYTES(2), .HEADER(8'hA5), .CSUM_EN(1'b0)) dut0 (
    .CLK(CLK), .rst_n(rst_n), .status_req(status_req), .status_mask(status_mask),
    .status_in(status_in), .tx_ready(tx_ready), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .BUSY(BUSY0), .req_dropped(req_dropped0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Caller has just stepped past the event edge; header should be presented.
  task automatic expect_frame(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(fr[i]));
      step();
    end
    chk({tag, "_end_valid"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    int nv;
    rst_n       = 1'b0;
    status_req  = 1'b0;
    status_mask = 4'b0000;
    status_in   = {16'h1357, 16'hBEEF, 16'h5555, 16'h1234};
    tx_ready    = 1'b1;
    #3;
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_drop", 32'(req_dropped), 32'd0);
    #20 rst_n = 1'b1;
    step();
    step();

    // basic frame
    fr = '{8'hA5, 8'h05, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hD7, 8'h00};
    status_mask = 4'b0101;
    status_req  = 1'b1;
    step();
    status_req = 1'b0;
    chk("basic_busy", 32'(BUSY), 32'd1);
    expect_frame("basic", 7);
    chk("basic_busy_end", 32'(BUSY), 32'd0);
    step();

    // backpressure while 34 is presented
    status_req = 1'b1;
    step();
    status_req = 1'b0;
    chk("bp_hdr", 32'(tx_data), 32'hA5);
    step();
    chk("bp_mask", 32'(tx_data), 32'h05);
    step();
    chk("bp_d0", 32'(tx_data), 32'h34);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", 32'(tx_data), 32'h34);
      chk("bp_hold_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    fr = '{8'h34, 8'h12, 8'hEF, 8'hBE, 8'hD7, 8'h00, 8'h00, 8'h00};
    expect_frame("bp", 5);
    step();

    // empty mask, with and without checksum
    status_mask = 4'b0000;
    status_req  = 1'b1;
    step();
    status_req = 1'b0;
    chk("empty_hdr", 32'(tx_data), 32'hA5);
    chk("empty0_hdr", 32'(tx_data0), 32'hA5);
    step();
    chk("empty_mask", 32'(tx_data), 32'h00);
    chk("empty0_mask", 32'(tx_data0), 32'h00);
    chk("empty0_mask_valid", 32'(tx_valid0), 32'd1);
    step();
    chk("empty_csum", 32'(tx_data), 32'hA5);
    chk("empty_csum_valid", 32'(tx_valid), 32'd1);
    chk("empty0_done_valid", 32'(tx_valid0), 32'd0);
    chk("empty0_done_busy", 32'(BUSY0), 32'd0);
    step();
    chk("empty_done_valid", 32'(tx_valid), 32'd0);
    chk("empty_done_busy", 32'(BUSY), 32'd0);
    step();

    // queueing: second event pends, third is dropped
    status_mask = 4'b0101;
    status_req  = 1'b1;
    step();
    status_req = 1'b0;
    chk("q_hdr", 32'(tx_data), 32'hA5);
    step();
    chk("q_mask", 32'(tx_data), 32'h05);
    status_mask = 4'b1000;
    status_req  = 1'b1;
    step();
    status_req = 1'b0;
    chk("q_d0", 32'(tx_data), 32'h34);
    chk("q_no_drop", 32'(req_dropped), 32'd0);
    step();
    chk("q_d1", 32'(tx_data), 32'h12);
    status_mask = 4'b0010;
    status_req  = 1'b1;
    step();
    status_req = 1'b0;
    chk("q_d2", 32'(tx_data), 32'hEF);
    chk("q_drop", 32'(req_dropped), 32'd1);
    step();
    chk("q_d3", 32'(tx_data), 32'hBE);
    chk("q_drop_pulse", 32'(req_dropped), 32'd0);
    step();
    chk("q_csum", 32'(tx_data), 32'hD7);
    step();
    chk("q_gap_valid", 32'(tx_valid), 32'd0);
    chk("q_gap_busy", 32'(BUSY), 32'd1);
    step();
    fr = '{8'hA5, 8'h08, 8'h57, 8'h13, 8'hE9, 8'h00, 8'h00, 8'h00};
    expect_frame("q2", 5);
    chk("q2_busy_end", 32'(BUSY), 32'd0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tx_valid) nv++;
    end
    chk("q_no_third", 32'(nv), 32'd0);

    // level request held high produces one frame
    status_mask = 4'b0001;
    status_req  = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_valid) nv++;
    end
    status_req = 1'b0;
    chk("level_cycles", 32'(nv), 32'd5);
    step();
    chk("level_idle", 32'(tx_valid), 32'd0);

    // reset during DATA with request still high
    status_mask = 4'b0101;
    status_req  = 1'b1;
    step();
    step();
    step();
    chk("rstmid_d0", 32'(tx_data), 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(tx_valid), 32'd0);
    chk("rstmid_busy", 32'(BUSY), 32'd0);
    chk("rstmid_data", 32'(tx_data), 32'h00);
    step();
    #3 rst_n = 1'b1;
    step();
    fr = '{8'hA5, 8'h05, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hD7, 8'h00};
    expect_frame("rstmid", 7);
    status_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rstmid_one_frame", 32'(tx_valid), 32'd0);
    chk("rstmid_busy_end", 32'(BUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_status_frame.md
# cmd_status_frame

Parametrised status responder for the command path: on a request it snapshots up to eight status channels and streams them to the UART transmitter as a framed byte sequence. Every byte uses a full valid/ready handshake. Each frame carries a header, a channel mask and an optional XOR checksum. One request can be queued while a frame is in flight. Sits between the command decoder and the UART TX byte interface.

## Interface
- NUM_CH, 4: number of status channels, 1..8
- CH_BYTES, 1: bytes per channel, 1..4
- HEADER, 8'hA5: first byte of every frame
- CSUM_EN, 1: 1 appends XOR checksum byte
- CLK  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- status_req  in  1  level request; rising edge (sampled) starts a frame
- status_mask  in  NUM_CH  channels to include, captured with the request edge
- status_in  in  NUM_CH*CH_BYTES*8  channel c occupies bits [c*CH_BYTES*8 +: CH_BYTES*8]
- tx_ready  in  1  UART TX can accept a byte
- tx_data  out  8  byte presented
- tx_valid  out  1  tx_data valid
- BUSY  out  1  frame in flight or pending
- req_dropped  out  1  one-cycle pulse: request lost (pending slot full)

## Operation
- Reset values: tx_data=8'h00, tx_valid=0, BUSY=0, req_dropped=0, state IDLE, pending empty, edge register 0.
- Request event = status_req high at this edge AND low at previous edge. A level held high produces exactly one event.
- States: IDLE, HDR, MASK, DATA, CSUM.
- IDLE: on event (or pending valid), capture mask (from event or pending slot) and status_in snapshot. Load tx_data=HEADER, tx_valid=1, BUSY=1, go to HDR. An event has priority over pending only if pending is empty (pending is never simultaneously valid in IDLE with an event).
- Byte transfer = tx_valid && tx_ready at an edge. tx_data and tx_valid are stable until the transfer.
- HDR, on transfer: present {(8-NUM_CH)'0, mask}, go to MASK.
- MASK, on transfer: if the mask is nonzero, present the lowest selected channel byte 0 and go to DATA; else go to CSUM (or finish if CSUM_EN=0).
- DATA: selected channels in ascending index, each LSB byte first. After the last byte of the highest selected channel, go to CSUM (or finish).
- CSUM: the byte is the XOR of all prior frame bytes including HEADER and mask. Finish on transfer.
- Finish: tx_valid=0, state IDLE. BUSY=0 only if no pending request.
- Event while BUSY: stored in the pending slot (mask only; status_in is sampled at that frame's start). If pending is already full, req_dropped=1 for one cycle and the event is discarded.
- Event on the same edge as finish goes to pending; it is never dropped.

## Timing
- Event sampled at edge k: tx_valid=1, tx_data=HEADER visible after edge k. Zero-bubble byte-to-byte under tx_ready=1.
- Frame length = 2 + popcount(mask)*CH_BYTES + CSUM_EN bytes.
- Pending frame: header presented at the edge after finish. BUSY stays 1 across the gap.
- rst_n assertion mid-frame: all outputs go to reset values immediately. The frame and pending request are abandoned. The edge register clears, so a status_req still high after release triggers a frame.

## Structure
- Shared package cmd_pkg: state enum, DEFAULT_HEADER constant, max-channel constant (8).
- One sub-module: cmd_req_edge (registered rising-edge detector, async active-low reset).
- Channel walk uses a priority find-next over the captured mask. Byte index counter width is clog2(CH_BYTES).

## Test plan
Configuration for all scenarios: NUM_CH=4, CH_BYTES=2, HEADER=A5, CSUM_EN=1.
- Basic frame: mask=4'b0101, ch0=16'h1234, ch2=16'hBEEF, tx_ready=1 -> bytes A5,05,34,12,EF,BE,D7 on 7 consecutive cycles; BUSY falls after the D7 transfer.
- Backpressure: same frame, tx_ready=0 for 3 cycles while 34 is presented -> tx_data holds 34 and tx_valid stays 1; byte order and checksum are unchanged.
- Empty mask: mask=0 -> A5,00,A5. With CSUM_EN=0 -> A5,00 only.
- Queueing: second event mid-frame (mask=4'b1000) -> second frame starts one cycle after the first finishes. A third event during the first frame -> req_dropped pulses for one cycle and no third frame is sent.
- Level request: status_req held high 20 cycles -> exactly one frame.
- Reset mid-frame: rst_n low during DATA -> tx_valid=0, BUSY=0 without waiting for a clock. After release with status_req high -> one new frame.
